// File: rtl/player_select_pkg.sv
// rtl/player_select_pkg.sv - shared state encoding and game-wide player-count limits
package player_select_pkg;

    localparam int GAME_MIN_PLAYERS = 1;
    localparam int GAME_MAX_PLAYERS = 4;

    typedef enum logic {
        SELECT  = 1'b0,
        PLAYING = 1'b1
    } sel_state_t;

endpackage

// File: rtl/player_select_btn_repeat.sv
// rtl/player_select_btn_repeat.sv - button rise-edge detector with hold-to-auto-repeat step pulses
module btn_repeat #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    input  logic enable,
    output logic step
);

    localparam int CW = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1;
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic          r_level_q;
    logic          r_repeat;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] r_rep_cnt;

    logic w_active;
    logic w_rise;
    logic w_hold_exp;
    logic w_rep_exp;

    assign w_active   = enable & level;
    assign w_rise     = level & ~r_level_q;
    assign w_hold_exp = ~r_repeat & (r_hold_cnt == HOLD_TC);
    assign w_rep_exp  = r_repeat & (r_rep_cnt == REP_TC);
    assign step       = w_active & (w_rise | w_hold_exp | w_rep_exp);

    // Counting only starts from a genuine rise; a level that is already high
    // (held through reset, or left over after both buttons) stays idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_q  <= 1'b1;
            r_repeat   <= 1'b0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
        end else begin
            r_level_q <= level;
            if (!w_active) begin
                r_repeat   <= 1'b0;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
            end else if (w_rise) begin
                r_repeat   <= 1'b0;
                r_hold_cnt <= ONE;
                r_rep_cnt  <= '0;
            end else if (r_repeat) begin
                r_rep_cnt <= w_rep_exp ? ONE : r_rep_cnt + ONE;
            end else if (r_hold_cnt != '0) begin
                if (w_hold_exp) begin
                    r_repeat   <= 1'b1;
                    r_hold_cnt <= '0;
                    r_rep_cnt  <= ONE;
                end else begin
                    r_hold_cnt <= r_hold_cnt + ONE;
                end
            end
        end
    end

endmodule

// File: rtl/player_select.sv
// rtl/player_select.sv - player-count selection and select/play state machine with game_start pulse
module player_select
    import player_select_pkg::*;
#(
    parameter int MIN_PLAYERS   = GAME_MIN_PLAYERS,
    parameter int MAX_PLAYERS   = GAME_MAX_PLAYERS,
    parameter int CNT_W         = 3,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             start,
    input  logic             game_over,
    output logic [CNT_W-1:0] players,
    output logic             game_start,
    output logic             in_game,
    output logic             sel_active
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PLAYERS);
    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PLAYERS);

    sel_state_t       r_state;
    sel_state_t       w_next_state;
    logic             r_start_q;
    logic             r_game_start;
    logic [CNT_W-1:0] r_players;

    logic w_sel;
    logic w_both;
    logic w_enable;
    logic w_rise_start;
    logic w_launch;
    logic w_up_step;
    logic w_down_step;
    logic w_step_up;
    logic w_step_down;

    assign w_sel        = (r_state == SELECT);
    assign w_both       = up & down;
    assign w_enable     = w_sel & ~w_both;
    assign w_rise_start = start & ~r_start_q;
    assign w_launch     = w_sel & w_rise_start;

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_up_rpt (
        .clk    (clk),
        .rst    (rst),
        .level  (up),
        .enable (w_enable),
        .step   (w_up_step)
    );

    btn_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_down_rpt (
        .clk    (clk),
        .rst    (rst),
        .level  (down),
        .enable (w_enable),
        .step   (w_down_step)
    );

    // A launch edge takes precedence over any coincident step.
    assign w_step_up   = w_up_step & ~down & ~w_launch;
    assign w_step_down = w_down_step & ~up & ~w_launch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SELECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SELECT:  if (w_rise_start) w_next_state = PLAYING;
            PLAYING: if (game_over)    w_next_state = SELECT;
            default: w_next_state = SELECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_q    <= 1'b1;
            r_game_start <= 1'b0;
            r_players    <= MIN_P;
        end else begin
            r_start_q    <= start;
            r_game_start <= w_launch;
            if (w_step_up && (r_players < MAX_P)) begin
                r_players <= r_players + CNT_W'(1);
            end else if (w_step_down && (r_players > MIN_P)) begin
                r_players <= r_players - CNT_W'(1);
            end
        end
    end

    assign players    = r_players;
    assign game_start = r_game_start;
    assign in_game    = (r_state == PLAYING);
    assign sel_active = (r_state == SELECT);

endmodule

// File: tb/tb_player_select.sv
// tb/tb_player_select.sv - directed self-checking bench for player_select
module tb_player_select;

    logic       clk;
    logic       rst;
    logic       up;
    logic       down;
    logic       start;
    logic       game_over;
    logic [2:0] players;
    logic       game_start;
    logic       in_game;
    logic       sel_active;

    int n_tests = 0;
    int n_fail  = 0;

    player_select #(
        .MIN_PLAYERS   (1),
        .MAX_PLAYERS   (4),
        .CNT_W         (3),
        .HOLD_CYCLES   (4),
        .REPEAT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (up),
        .down       (down),
        .start      (start),
        .game_over  (game_over),
        .players    (players),
        .game_start (game_start),
        .in_game    (in_game),
        .sel_active (sel_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_up();
        up = 1'b1; tick(); up = 1'b0; tick();
    endtask

    task automatic pulse_down();
        down = 1'b1; tick(); down = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1; up = 1'b1; down = 1'b0; start = 1'b0; game_over = 1'b0;
        tick(); tick();
        chk("rst_players", 32'(players), 1);
        chk("rst_sel_active", 32'(sel_active), 1);
        chk("rst_in_game", 32'(in_game), 0);
        chk("rst_game_start", 32'(game_start), 0);

        // up held across reset release produces no event
        rst = 1'b0;
        tick(); tick();
        chk("held_through_rst", 32'(players), 1);
        up = 1'b0; tick();
        up = 1'b1; tick();
        chk("first_rise", 32'(players), 2);
        up = 1'b0; tick();

        pulse_up();   chk("up_to_3", 32'(players), 3);
        pulse_up();   chk("up_to_4", 32'(players), 4);
        pulse_up();   chk("up_sat_4a", 32'(players), 4);
        pulse_up();   chk("up_sat_4b", 32'(players), 4);
        pulse_down(); chk("down_to_3", 32'(players), 3);
        pulse_down(); chk("down_to_2", 32'(players), 2);
        pulse_down(); chk("down_to_1", 32'(players), 1);
        pulse_down(); chk("down_sat_1a", 32'(players), 1);
        pulse_down(); chk("down_sat_1b", 32'(players), 1);

        // hold up: steps on edges 0, 4, 6 then saturates
        up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold_up_%0d", i), 32'(players), (i < 4) ? 2 : (i < 6) ? 3 : 4);
        end
        up = 1'b0; tick(); tick();
        chk("hold_up_release", 32'(players), 4);

        down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold_down_%0d", i), 32'(players), (i < 4) ? 3 : (i < 6) ? 2 : 1);
        end
        down = 1'b0; tick(); tick();

        pulse_up(); chk("pre_both", 32'(players), 2);
        up = 1'b1; down = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("both_%0d", i), 32'(players), 2);
        end
        up = 1'b0; down = 1'b0; tick(); tick();
        chk("both_release", 32'(players), 2);

        // start coinciding with up: start wins
        start = 1'b1; up = 1'b1;
        tick();
        chk("launch_game_start", 32'(game_start), 1);
        chk("launch_in_game", 32'(in_game), 1);
        chk("launch_sel_active", 32'(sel_active), 0);
        chk("launch_players", 32'(players), 2);
        up = 1'b0;
        tick();
        chk("pulse_one_cycle", 32'(game_start), 0);
        chk("still_in_game", 32'(in_game), 1);
        pulse_up(); pulse_up();
        chk("frozen_players", 32'(players), 2);
        chk("frozen_game_start", 32'(game_start), 0);

        // game_over with start still held returns to SELECT without relaunch
        game_over = 1'b1;
        tick();
        chk("go_sel_active", 32'(sel_active), 1);
        chk("go_in_game", 32'(in_game), 0);
        chk("go_players", 32'(players), 2);
        chk("go_game_start", 32'(game_start), 0);
        game_over = 1'b0;
        tick();
        chk("no_relaunch_gs", 32'(game_start), 0);
        chk("no_relaunch_sel", 32'(sel_active), 1);
        start = 1'b0; tick();

        start = 1'b1;
        tick();
        chk("relaunch_gs", 32'(game_start), 1);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_players", 32'(players), 1);
        chk("midrst_sel_active", 32'(sel_active), 1);
        chk("midrst_in_game", 32'(in_game), 0);
        chk("midrst_game_start", 32'(game_start), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_players", 32'(players), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/player_select.md
Name: player_select

Overview:
- Consumes the registered button levels (up, down, start) from the button-input stage.
- Converts them to rising-edge events with hold-to-auto-repeat.
- Maintains a saturating player-count register and runs the select/play state machine.
- Issues a single-cycle game_start pulse to the game core and freezes the player count until the game core signals game_over.

Parameters:
- MIN_PLAYERS, 1, lowest selectable player count; also the reset value of players.
- MAX_PLAYERS, 4, highest selectable player count.
- CNT_W, 3, width of players; must hold MAX_PLAYERS.
- HOLD_CYCLES, 50000000, cycles a single direction is held before auto-repeat begins.
- REPEAT_CYCLES, 12500000, cycles between auto-repeat steps once repeating.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- up  input  1  registered level, player count up.
- down  input  1  registered level, player count down.
- start  input  1  registered level, start game.
- game_over  input  1  level from game core; returns the block to selection.
- players  output  CNT_W  currently selected player count.
- game_start  output  1  one-cycle pulse when a game is launched.
- in_game  output  1  high while in PLAYING.
- sel_active  output  1  high while in SELECT.

Behaviour:
- Reset (async, rst=1):
  - players=MIN_PLAYERS, game_start=0, in_game=0, sel_active=1, state=SELECT.
  - Hold and repeat counters are 0.
  - Edge registers up_q, down_q, start_q are set to 1, so a button already held when reset releases generates no event.
- Edge detect: rise_x = x & ~x_q; x_q <= x every cycle, in all states.
- States:
  - SELECT (sel_active=1): handles up/down stepping and start.
  - PLAYING (in_game=1): up, down and start are ignored and the counters are held at 0.
- SELECT -> PLAYING:
  - Occurs at the edge where rise_start=1.
  - game_start is high for exactly the following cycle.
  - players does not change on that edge, even if rise_up or rise_down coincides (start wins).
- PLAYING -> SELECT:
  - Occurs at the edge where game_over=1.
  - players retains its value; game_start stays 0.
  - rise_start on that same edge is ignored. The start edge register still updates, so a start held through the game does not immediately relaunch.
- Step (SELECT only):
  - A step up is players+1 if players<MAX_PLAYERS, else no change. A step down is players-1 if players>MIN_PLAYERS, else no change. Saturating, never wraps.
  - The new value is visible the cycle after the stepping edge.
  - A step up occurs on the edge where rise_up=1 and down=0.
  - A step down occurs on the edge where rise_down=1 and up=0.
  - up and down both high: no step; hold and repeat counters are cleared.
- Auto-repeat (SELECT, exactly one of up/down high):
  - The hold counter increments each cycle the same direction stays high, starting on the rise edge.
  - When the hold counter reaches HOLD_CYCLES, one step occurs and repeat mode is entered.
  - In repeat mode, a step occurs every REPEAT_CYCLES cycles.
  - Releasing the direction, or pressing both, clears both counters and exits repeat mode.
  - At saturation, repeat steps are no-ops; the counters keep running.
- Counter widths: $clog2 of the larger of HOLD_CYCLES and REPEAT_CYCLES, plus 1. No overflow is possible because counters are reset on reaching their terminal count.
- Mid-operation reset: any state returns immediately to the reset values; an in-flight game_start pulse is cancelled.

Decomposition:
- Shared package: state enum {SELECT, PLAYING}, and the MIN_PLAYERS/MAX_PLAYERS defaults as game-wide constants.
- One sub-module, btn_repeat, instanced twice (up, down).
  - Inputs: clk, rst, level, enable.
  - Output: a step pulse, asserted on the rise edge and on each hold/repeat expiry.
  - The parent masks each pulse when both directions are high and handles start precedence.

Test Plan (HOLD_CYCLES=4, REPEAT_CYCLES=2, MIN=1, MAX=4):
- Reset with up held high, release rst, keep up high 2 cycles -> players stays 1; then drop up, raise for 1 cycle -> players=2 the next cycle.
- Three single-cycle up pulses from 1 -> players 2, 3, 4; a fourth pulse -> stays 4. Five down pulses -> ends at 1, never 0 and never wraps to 7.
- Hold up continuously from players=1 -> steps at cycle 0 (to 2), cycle 4 (to 3), cycle 6 (to 4), then stays 4. Release and hold down -> same cadence downward.
- Raise up and down on the same edge -> players unchanged and no repeat steps while both are held.
- Raise start together with up at players=2 -> game_start=1 for exactly one cycle, in_game=1, players=2. Later up pulses -> players still 2.
- In PLAYING, assert game_over with start held -> sel_active=1, players unchanged, no game_start. Pulse rst mid-game -> players=1, sel_active=1, in_game=0 immediately.
